uart_rx_buffered: RTL and testbench
===================================

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit (115200 baud at 100 MHz).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning received-byte buffer entries (power of two, >= 2).
REQ-003 Port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port i_rx_serial  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-006 Port o_rx_byte  output  8  byte at FIFO head, valid while o_rx_valid=1.
REQ-007 Port o_rx_valid  output  1  FIFO not empty.
REQ-008 Port i_rx_ready  input  1  consumer accepts head byte when high with o_rx_valid.
REQ-009 Port o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 Port o_overrun  output  1  one-cycle pulse: completed byte dropped because FIFO full.
REQ-011 Port o_fifo_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Function
REQ-012 i_rx_serial SHALL pass through a 2-flop synchronizer before any use; synchronizer flops reset to 1.
REQ-013 The receive FSM SHALL have states IDLE, START, DATA, STOP, with one bit-timer counting 0..CLKS_PER_BIT-1 and a 3-bit bit index.
REQ-014 IDLE -> START on synchronized line low; timer cleared.
REQ-015 START: at timer = (CLKS_PER_BIT-1)/2 sample the line; low -> DATA (timer cleared, index 0); high -> IDLE (glitch, no output).
REQ-016 DATA: at timer = CLKS_PER_BIT-1 sample into shift register bit[index], LSB first; after index 7 -> STOP.
REQ-017 STOP: at timer = CLKS_PER_BIT-1 sample; high -> push byte; low -> pulse o_frame_err, discard byte; either case -> IDLE the next cycle.
REQ-018 Push SHALL occur in the cycle after the stop-bit sample; o_rx_valid SHALL rise the cycle after the push into an empty FIFO.
REQ-019 FIFO SHALL be show-ahead: o_rx_byte equals oldest entry whenever o_rx_valid=1; pop occurs on o_rx_valid & i_rx_ready.
REQ-020 Push with FIFO full and no same-cycle pop SHALL drop the new byte, keep contents, and pulse o_overrun.
REQ-021 Push and pop in the same cycle SHALL both succeed, including when full; count unchanged.
REQ-022 i_rx_ready with o_rx_valid=0 SHALL have no effect; pointers wrap modulo FIFO_DEPTH.
REQ-023 Frame error and overrun cannot coincide; each pulse lasts exactly one cycle.

Reset
REQ-024 Asserting i_rst_n low SHALL immediately force FSM to IDLE, timer, index and pointers to 0, o_fifo_count 0, o_rx_valid 0, o_rx_byte 0x00, o_frame_err 0, o_overrun 0.
REQ-025 Reset mid-frame SHALL discard the partial byte; after release the block SHALL wait for a fresh falling edge (line high first) before receiving.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state type and default CLKS_PER_BIT constant, shared with the existing TX/RX blocks.
REQ-027 The FIFO SHALL be a sub-module uart_sync_fifo (parameter DEPTH, width 8, show-ahead, count output).

Verification (CLKS_PER_BIT=868, 10 ns clock)
REQ-028 Serial 0xA6 with i_rx_ready=1 -> o_rx_valid high with o_rx_byte=0xA6 about 9.5 bit periods (~82.5 us) after start edge; no error pulses.
REQ-029 100 ns low glitch on idle line -> FSM returns to IDLE, no valid, no error.
REQ-030 Byte 0x3C with stop bit driven low -> single o_frame_err pulse, o_fifo_count stays 0.
REQ-031 Bytes 0x01..0x05 back-to-back, i_rx_ready=0 -> count 4, one o_overrun pulse on fifth; then ready=1 reads 0x01,0x02,0x03,0x04 in order, count returns 0.
REQ-032 Assert i_rst_n low during DATA bit 4 of 0xFF, release, then send 0x5A -> only 0x5A received, no errors.
REQ-033 Full FIFO with ready=1 held while next byte completes -> simultaneous push/pop, no overrun, count stays 4.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM state encoding and default bit timing.
`timescale 1ns/1ps
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 868;  // 115200 baud from a 100 MHz clock

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte-wide show-ahead synchronous FIFO with occupancy count; push on full is dropped
// unless a pop happens in the same cycle.
`timescale 1ns/1ps
module uart_sync_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [7:0]                   push_data,
  input  logic                         pop,
  output logic [7:0]                   head,
  output logic                         valid,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign head    = valid ? mem[rd_ptr] : 8'h00;

  // NOTE: storage is deliberately not reset; head is masked while empty so it still reads 0x00.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with mid-bit sampling, frame-error and overrun pulses, and a
// show-ahead byte FIFO toward the consumer.
`timescale 1ns/1ps
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_rx_serial,
  output logic [7:0]                        o_rx_byte,
  output logic                              o_rx_valid,
  input  logic                              i_rx_ready,
  output logic                              o_frame_err,
  output logic                              o_overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_BIT = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TW-1:0] LAST_CLK = TW'(CLKS_PER_BIT - 1);

  logic        rx_meta;
  logic        rx_sync;
  logic [1:0]  sync_fill;
  logic        armed;

  uart_state_e state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          push_n, push_q;
  logic          ferr_n;
  logic          fifo_full;

  // Until the synchronizer holds two real line samples its reset value is not trusted;
  // reception is armed only after the line has genuinely been seen high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep the two flops a true shift chain.
      rx_meta   <= i_rx_serial;
      rx_sync   <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (sync_fill[1] & rx_sync);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      push_q      <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      push_q      <= push_n;
      o_frame_err <= ferr_n;
      o_overrun   <= push_q & fifo_full & ~(o_rx_valid & i_rx_ready);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_n   = state;
    timer_n   = timer + TW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    push_n    = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        timer_n   = '0;
        bit_idx_n = '0;
        if (armed && !rx_sync) state_n = START;
      end
      START: begin
        if (timer == HALF_BIT) begin
          timer_n = '0;
          state_n = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == LAST_CLK) begin
          timer_n          = '0;
          shift_n[bit_idx] = rx_sync;
          bit_idx_n        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (timer == LAST_CLK) begin
          timer_n = '0;
          state_n = IDLE;
          push_n  = rx_sync;
          ferr_n  = ~rx_sync;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  uart_sync_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push_q),
    .push_data (shift),
    .pop       (i_rx_ready),
    .head      (o_rx_byte),
    .valid     (o_rx_valid),
    .full      (fifo_full),
    .count     (o_fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered with a shortened bit time.
`timescale 1ns/1ps
module tb_uart_rx_buffered;

  localparam int CPB   = 100;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int st = 0;
  int lat = 0;
  logic [7:0] pop_q [$];
  int         pop_cyc [$];

  always #5 clk = ~clk;

  uart_rx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx_serial  (rx_line),
    .o_rx_byte    (rx_byte),
    .o_rx_valid   (rx_valid),
    .i_rx_ready   (ready),
    .o_frame_err  (frame_err),
    .o_overrun    (overrun),
    .o_fifo_count (fifo_count)
  );

  // Consumer side: log every accepted byte and count pulse cycles.
  always @(posedge clk) begin
    cyc++;
    if (rx_valid && ready) begin
      pop_q.push_back(rx_byte);
      pop_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pop_at(input int k);
    if (k < pop_q.size()) return pop_q[k];
    return 8'hxx;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_line = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", rx_valid, 0);
    check("rst_byte", rx_byte, 8'h00);
    check("rst_count", fifo_count, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);

    // 0xA6 with consumer ready: valid after ~9.5 bit times
    ready = 1'b1;
    st = cyc;
    send_byte(8'hA6, 1'b1);
    repeat (CPB) @(negedge clk);
    check("a6_pops", pop_q.size(), 1);
    check("a6_byte", pop_at(0), 8'hA6);
    lat = (pop_cyc.size() > 0) ? pop_cyc[0] - st : -1;
    check("a6_latency_in_window", (lat >= 945 && lat <= 965), 1);
    check("a6_ferr", ferr_cnt, 0);
    check("a6_ovr", ovr_cnt, 0);

    // 100 ns glitch on idle line
    rx_line = 1'b0;
    repeat (10) @(negedge clk);
    rx_line = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_pops", pop_q.size(), 1);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", ferr_cnt, 0);

    // 0x3C with low stop bit
    send_byte(8'h3C, 1'b0);
    repeat (CPB) @(negedge clk);
    check("ferr_pulse_cycles", ferr_cnt, 1);
    check("ferr_count", fifo_count, 0);
    check("ferr_pops", pop_q.size(), 1);

    // 0x01..0x05 back-to-back, consumer stalled
    ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b1);
    check("fill4_count", fifo_count, 4);
    check("fill4_ovr", ovr_cnt, 0);
    send_byte(8'h05, 1'b1);
    check("ovr_pulse_cycles", ovr_cnt, 1);
    check("ovr_count", fifo_count, 4);
    check("ovr_valid", rx_valid, 1);
    check("ovr_head", rx_byte, 8'h01);

    // Full FIFO: pop in the same cycle the next byte (0x06) is pushed
    fork
      send_byte(8'h06, 1'b1);
      begin
        repeat (953) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    repeat (CPB) @(negedge clk);
    check("simul_ovr", ovr_cnt, 1);
    check("simul_count", fifo_count, 4);
    check("simul_pops", pop_q.size(), 2);
    check("simul_pop_byte", pop_at(1), 8'h01);

    // Drain
    ready = 1'b1;
    repeat (10) @(negedge clk);
    ready = 1'b0;
    check("drain_b2", pop_at(2), 8'h02);
    check("drain_b3", pop_at(3), 8'h03);
    check("drain_b4", pop_at(4), 8'h04);
    check("drain_b6", pop_at(5), 8'h06);
    check("drain_count", fifo_count, 0);
    check("drain_valid", rx_valid, 0);

    // Reset during data bit 4 of 0xFF with a byte buffered
    send_byte(8'h77, 1'b1);
    repeat (CPB) @(negedge clk);
    check("pre_rst_count", fifo_count, 1);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_line = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_count", fifo_count, 0);
    check("midrst_valid", rx_valid, 0);
    check("midrst_byte", rx_byte, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6 * CPB) @(negedge clk);
    ready = 1'b1;
    send_byte(8'h5A, 1'b1);
    repeat (CPB) @(negedge clk);
    check("post_rst_pops", pop_q.size(), 7);
    check("post_rst_byte", pop_at(6), 8'h5A);
    check("post_rst_ferr", ferr_cnt, 1);
    check("post_rst_ovr", ovr_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
